audio_pkt_framer: RTL

- Consumer stage directly downstream of the audio data packet distributed FIFO.
- Monitors the FIFO read water level. Once a full packet of samples is buffered, drains exactly PKT_LEN words and emits them as a framed stream: header word, payload, optional checksum trailer.
- Drives a valid/ready sink, e.g. the UDP/Ethernet transmit path.
- FIFO is used in show-ahead mode (OUT_REG=0): fifo_rd_data holds the head word whenever fifo_empty=0, and fifo_rd_en pops it.

---
 rtl/audio_pkt_pkg.sv | 38 +++
 rtl/audio_pkt_out_reg.sv | 50 +++++
 rtl/audio_pkt_framer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/audio_pkt_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkt_pkg
// Shared definitions for the audio packet framer:
//   - FSM state encoding (IDLE, PAYLOAD, CHKSUM)
//   - default header sync pattern
//   - header field positions (SYNC 31:16, SEQ 15:8, LEN 7:0)
//   - build_header(): assembles the 32-bit header word
// -----------------------------------------------------------------------------
package audio_pkt_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_PAYLOAD = 2'd1;
  localparam state_t ST_CHKSUM  = 2'd2;

  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA55A;

  localparam int HDR_SYNC_MSB = 31;
  localparam int HDR_SYNC_LSB = 16;
  localparam int HDR_SEQ_MSB  = 15;
  localparam int HDR_SEQ_LSB  = 8;
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 0;

  // The length field carries PKT_LEN-1 so that a 256-word packet fits in 8 bits.
  function automatic logic [31:0] build_header(input logic [15:0] sync,
                                               input logic [7:0]  seq,
                                               input logic [7:0]  len_m1);
    logic [31:0] hdr;
    hdr = '0;
    hdr[HDR_SYNC_MSB:HDR_SYNC_LSB] = sync;
    hdr[HDR_SEQ_MSB:HDR_SEQ_LSB]   = seq;
    hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = len_m1;
    return hdr;
  endfunction

endpackage

// File: rtl/audio_pkt_out_reg.sv
// -----------------------------------------------------------------------------
// audio_pkt_out_reg
// Single-entry valid/ready output register. A word offered on load is captured
// whenever the slot is free (empty, or being drained this cycle); while the sink
// stalls (m_valid & !m_ready) data, sop and eop hold stable.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   load, load_data, load_sop/eop    word offered by the framer (only when slot_free)
//   m_ready                          sink ready
//   m_data, m_valid, m_sop, m_eop    registered stream outputs
//   slot_free                        register can accept a word this cycle
// -----------------------------------------------------------------------------
module audio_pkt_out_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_sop,
  input  logic                  load_eop,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_sop,
  output logic                  m_eop,
  output logic                  slot_free
);

  assign slot_free = !m_valid || m_ready;

  // On a free slot the register either takes the new word or goes empty;
  // the payload fields are only rewritten on a load so they stay put while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_sop   <= 1'b0;
      m_eop   <= 1'b0;
    end else if (slot_free) begin
      m_valid <= load;
      if (load) begin
        m_data <= load_data;
        m_sop  <= load_sop;
        m_eop  <= load_eop;
      end
    end
  end

endmodule

// File: rtl/audio_pkt_framer.sv
// -----------------------------------------------------------------------------
// audio_pkt_framer
// Drains the audio sample FIFO (show-ahead) one packet at a time once PKT_LEN
// words are buffered, and emits header + payload (+ optional checksum) on a
// valid/ready stream.
// Optional feature: define AUDIO_PKT_CHKSUM_EN to append a 32-bit sum of the
// payload words as a trailer word (packet becomes PKT_LEN+2 words).
// Ports:
//   clk, rst_n              clock, async active-low reset
//   enable                  allows a new packet to start (checked in IDLE only)
//   fifo_rd_data            FIFO head word
//   fifo_empty              FIFO empty flag
//   fifo_rd_water_level     FIFO occupancy
//   fifo_rd_en              FIFO pop (combinational)
//   m_data/m_valid/m_ready  output stream
//   m_sop, m_eop            packet delimiters
//   busy                    not in IDLE
//   pkt_seq                 sequence number of the next packet
//   pkt_done                pulse the cycle after the EOP word is accepted
// -----------------------------------------------------------------------------
module audio_pkt_framer
  import audio_pkt_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 10,
  parameter int          PKT_LEN    = 256,
  parameter logic [15:0] SYNC_WORD  = SYNC_WORD_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic [ADDR_WIDTH:0]   fifo_rd_water_level,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_sop,
  output logic                  m_eop,
  output logic                  busy,
  output logic [7:0]            pkt_seq,
  output logic                  pkt_done
);

  localparam int                CNT_W     = 9;
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(PKT_LEN - 1);
  localparam logic [ADDR_WIDTH:0] PKT_LEVEL = (ADDR_WIDTH + 1)'(PKT_LEN);
  localparam logic [7:0]        LEN_FIELD = 8'(PKT_LEN - 1);

  state_t                  state;
  logic [CNT_W-1:0]        count;
  logic                    slot_free;
  logic                    hdr_load;
  logic                    pop;
  logic                    last_pop;
  logic                    load;
  logic                    load_sop;
  logic                    load_eop;
  logic [DATA_WIDTH-1:0]   load_data;

`ifdef AUDIO_PKT_CHKSUM_EN
  logic [31:0]             chk_sum;
  logic                    chk_load;
`endif

  assign hdr_load   = (state == ST_IDLE) && enable &&
                      (fifo_rd_water_level >= PKT_LEVEL) && slot_free;
  assign pop        = (state == ST_PAYLOAD) && slot_free && !fifo_empty;
  assign last_pop   = pop && (count == LAST_CNT);
  assign fifo_rd_en = pop;
  assign busy       = (state != ST_IDLE);

`ifdef AUDIO_PKT_CHKSUM_EN
  assign chk_load   = (state == ST_CHKSUM) && slot_free;
`endif

  // Select the word offered to the output register. A stall on the FIFO side
  // simply offers nothing, so no bubble word is ever inserted.
  always_comb begin
    load      = 1'b0;
    load_data = '0;
    load_sop  = 1'b0;
    load_eop  = 1'b0;
    if (hdr_load) begin
      load      = 1'b1;
      load_data = DATA_WIDTH'(build_header(SYNC_WORD, pkt_seq, LEN_FIELD));
      load_sop  = 1'b1;
    end else if (pop) begin
      load      = 1'b1;
      load_data = fifo_rd_data;
`ifdef AUDIO_PKT_CHKSUM_EN
      load_eop  = 1'b0;
`else
      load_eop  = last_pop;
`endif
    end
`ifdef AUDIO_PKT_CHKSUM_EN
    else if (chk_load) begin
      load      = 1'b1;
      load_data = DATA_WIDTH'(chk_sum);
      load_eop  = 1'b1;
    end
`endif
  end

  // Packet sequencing: the header load bumps pkt_seq, each pop advances the
  // payload count, and the final pop ends the packet (or moves to the trailer).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      count   <= '0;
      pkt_seq <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hdr_load) begin
            state   <= ST_PAYLOAD;
            count   <= '0;
            pkt_seq <= pkt_seq + 8'd1;
          end
        end
        ST_PAYLOAD: begin
          if (pop) begin
            count <= count + CNT_W'(1);
            if (last_pop) begin
`ifdef AUDIO_PKT_CHKSUM_EN
              state <= ST_CHKSUM;
`else
              state <= ST_IDLE;
`endif
            end
          end
        end
        ST_CHKSUM: begin
`ifdef AUDIO_PKT_CHKSUM_EN
          if (chk_load) state <= ST_IDLE;
`else
          state <= ST_IDLE;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef AUDIO_PKT_CHKSUM_EN
  // Running sum of the low 32 bits of each payload word, restarted per packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_sum <= 32'd0;
    end else if (hdr_load) begin
      chk_sum <= 32'd0;
    end else if (pop) begin
      chk_sum <= chk_sum + fifo_rd_data[31:0];
    end
  end
`endif

  // pkt_done follows the handshake of the EOP word by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= m_valid && m_ready && m_eop;
    end
  end

  audio_pkt_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
    .load_sop  (load_sop),
    .load_eop  (load_eop),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_sop     (m_sop),
    .m_eop     (m_eop),
    .slot_free (slot_free)
  );

endmodule
